// File: rtl/conv_transpose2.sv
// Transposed 2-D convolution (col2im scatter-accumulate): every snapshot pixel is
// multiplied by the whole kernel and added into its output window, one pixel per two cycles.
module conv_transpose2 #(
    parameter int SIZE      = 5,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8,
    parameter int ACC_BIT   = 20
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        start,
    input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    input  logic signed [WIDTH_BIT-1:0] kernel [SIZEKer][SIZEKer],
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_BIT-1:0]   deconvOut [SIZE+SIZEKer-1][SIZE+SIZEKer-1]
);

    localparam int OUT = SIZE + SIZEKer - 1;
    localparam int IW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int OW  = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int PW  = 2 * WIDTH_BIT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ACCUM  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic [IW-1:0]                i_r;
    logic [IW-1:0]                j_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         last_s;
    logic signed [WIDTH_BIT-1:0]  operand_r;
    logic signed [WIDTH_BIT-1:0]  snap_x_r [SIZE][SIZE];
    logic signed [WIDTH_BIT-1:0]  snap_k_r [SIZEKer][SIZEKer];
    logic signed [ACC_BIT-1:0]    acc_r [OUT][OUT];
    logic signed [ACC_BIT-1:0]    acc_nxt_s [OUT][OUT];
    logic signed [ACC_BIT-1:0]    out_r [OUT][OUT];

    assign last_s    = (i_r == IW'(SIZE - 1)) && (j_r == IW'(SIZE - 1));
    assign busy      = busy_r;
    assign done      = done_r;
    assign deconvOut = out_r;

    // Next-state selection for the fetch/accumulate sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: state_nxt_s = ACCUM;
            ACCUM: begin
                if (last_s) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Accumulator update: clear on accepted start, scatter one pixel's window in ACCUM
    always_comb begin
        logic signed [PW-1:0] prod_v;
        logic [OW-1:0]        row_v;
        logic [OW-1:0]        col_v;
        prod_v    = '0;
        row_v     = '0;
        col_v     = '0;
        acc_nxt_s = acc_r;
        if ((state_r == IDLE) && start) begin
            acc_nxt_s = '{default: '0};
        end else if (state_r == ACCUM) begin
            for (int u = 0; u < SIZEKer; u++) begin
                for (int v = 0; v < SIZEKer; v++) begin
                    prod_v = operand_r * snap_k_r[u][v];
                    row_v  = OW'(i_r) + OW'(u);
                    col_v  = OW'(j_r) + OW'(v);
                    acc_nxt_s[row_v][col_v] = acc_r[row_v][col_v]
                        + {{(ACC_BIT - PW){prod_v[PW-1]}}, prod_v};
                end
            end
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Sequencer state, indices, snapshots, accumulators and registered outputs
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r   <= IDLE;
            i_r       <= '0;
            j_r       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            operand_r <= '0;
            snap_x_r  <= '{default: '0};
            snap_k_r  <= '{default: '0};
            acc_r     <= '{default: '0};
            out_r     <= '{default: '0};
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        snap_x_r <= inpMatrixI;
                        snap_k_r <= kernel;
                        i_r      <= '0;
                        j_r      <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                FETCH: operand_r <= snap_x_r[i_r][j_r];
                ACCUM: begin
                    // Indices stay on the last pixel when finishing so they never leave range
                    if (!last_s) begin
                        if (j_r == IW'(SIZE - 1)) begin
                            j_r <= '0;
                            i_r <= i_r + IW'(1);
                        end else begin
                            j_r <= j_r + IW'(1);
                        end
                    end
                end
                FINISH: begin
                    out_r  <= acc_r;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_transpose2.sv
// Randomized and directed bench for conv_transpose2 against a gather-form reference
// (each output is the sum of all input*kernel pairs whose window covers it).
module tb_conv_transpose2;

    localparam int SIZE = 5;
    localparam int KS   = 3;
    localparam int WB   = 8;
    localparam int AB   = 20;
    localparam int OUT  = SIZE + KS - 1;
    localparam int LAT  = 2 * SIZE * SIZE + 1;

    logic                 clock;
    logic                 nreset;
    logic                 start;
    logic signed [WB-1:0] xin [SIZE][SIZE];
    logic signed [WB-1:0] kin [KS][KS];
    logic                 busy;
    logic                 done;
    logic signed [AB-1:0] dout [OUT][OUT];

    int mx [SIZE][SIZE];
    int mk [KS][KS];
    int expd [OUT][OUT];
    int n_cmp;
    int n_err;

    conv_transpose2 #(.SIZE(SIZE), .SIZEKer(KS), .WIDTH_BIT(WB), .ACC_BIT(AB)) dut (
        .clock(clock),
        .nreset(nreset),
        .start(start),
        .inpMatrixI(xin),
        .kernel(kin),
        .busy(busy),
        .done(done),
        .deconvOut(dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Gather form: out[p][q] = sum over kernel taps (u,v) of x[p-u][q-v]*k[u][v], wrapped to AB bits
    task automatic model();
        for (int p = 0; p < OUT; p++) begin
            for (int q = 0; q < OUT; q++) begin
                int s;
                logic signed [AB-1:0] w;
                s = 0;
                for (int u = 0; u < KS; u++) begin
                    for (int v = 0; v < KS; v++) begin
                        if (p - u >= 0 && p - u < SIZE && q - v >= 0 && q - v < SIZE)
                            s += mx[p-u][q-v] * mk[u][v];
                    end
                end
                w = s[AB-1:0];
                expd[p][q] = int'(w);
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) xin[i][j] = WB'(mx[i][j]);
        for (int u = 0; u < KS; u++)
            for (int v = 0; v < KS; v++) kin[u][v] = WB'(mk[u][v]);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) xin[i][j] = WB'($urandom_range(0, 255));
        for (int u = 0; u < KS; u++)
            for (int v = 0; v < KS; v++) kin[u][v] = WB'($urandom_range(0, 255));
    endtask

    task automatic randomize_model();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) mx[i][j] = $urandom_range(0, 255) - 128;
        for (int u = 0; u < KS; u++)
            for (int v = 0; v < KS; v++) mk[u][v] = $urandom_range(0, 255) - 128;
    endtask

    // One full operation: start, latency/handshake checks, then the whole output map
    task automatic run_op(input int id, input bit poke_start);
        int m;
        int busy_gaps;
        drive_inputs();
        model();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        scramble_inputs();
        check($sformatf("t%0d_busy_up", id), 32'(busy), 32'd1);
        m = 0;
        busy_gaps = 0;
        while (done !== 1'b1 && m < 200) begin
            start = (poke_start && m == 9) ? 1'b1 : 1'b0;
            @(negedge clock);
            m++;
            if (done !== 1'b1 && busy !== 1'b1) busy_gaps++;
        end
        start = 1'b0;
        check($sformatf("t%0d_latency", id), m, LAT);
        check($sformatf("t%0d_busy_gaps", id), busy_gaps, 0);
        check($sformatf("t%0d_busy_at_done", id), 32'(busy), 32'd0);
        for (int p = 0; p < OUT; p++)
            for (int q = 0; q < OUT; q++)
                check($sformatf("t%0d_out%0d_%0d", id, p, q), 32'(dout[p][q]), expd[p][q]);
        @(negedge clock);
        check($sformatf("t%0d_done_pulse", id), 32'(done), 32'd0);
        check($sformatf("t%0d_idle_busy", id), 32'(busy), 32'd0);
        check($sformatf("t%0d_hold", id), 32'(dout[OUT-1][OUT-1]), expd[OUT-1][OUT-1]);
    endtask

    function automatic int count_nonzero();
        int c;
        c = 0;
        for (int p = 0; p < OUT; p++)
            for (int q = 0; q < OUT; q++)
                if (dout[p][q] !== '0) c++;
        return c;
    endfunction

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        nreset = 1'b0;
        start  = 1'b0;
        for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) mx[i][j] = 0;
        for (int u = 0; u < KS; u++) for (int v = 0; v < KS; v++) mk[u][v] = 0;
        drive_inputs();
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_nonzero", count_nonzero(), 0);
        nreset = 1'b1;
        @(negedge clock);

        // Identity kernel
        for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) mx[i][j] = i * 5 + j;
        for (int u = 0; u < KS; u++) for (int v = 0; v < KS; v++) mk[u][v] = (u == 1 && v == 1) ? 1 : 0;
        run_op(1, 1'b1);
        check("t1_center", 32'(dout[3][4]), 32'sd13);
        check("t1_ring", 32'(dout[0][3]), 32'sd0);

        // Single pixel
        for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) mx[i][j] = (i == 2 && j == 2) ? 3 : 0;
        for (int u = 0; u < KS; u++) for (int v = 0; v < KS; v++) mk[u][v] = 3 * u + v + 1;
        run_op(2, 1'b0);
        check("t2_corner", 32'(dout[4][4]), 32'sd27);

        // All ones
        for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) mx[i][j] = 1;
        for (int u = 0; u < KS; u++) for (int v = 0; v < KS; v++) mk[u][v] = 1;
        run_op(3, 1'b0);
        check("t3_00", 32'(dout[0][0]), 32'sd1);
        check("t3_02", 32'(dout[0][2]), 32'sd3);
        check("t3_11", 32'(dout[1][1]), 32'sd4);
        check("t3_33", 32'(dout[3][3]), 32'sd9);
        check("t3_66", 32'(dout[6][6]), 32'sd1);

        // Signed corner
        for (int i = 0; i < SIZE; i++) for (int j = 0; j < SIZE; j++) mx[i][j] = -128;
        for (int u = 0; u < KS; u++) for (int v = 0; v < KS; v++) mk[u][v] = -128;
        run_op(4, 1'b1);
        check("t4_33", 32'(dout[3][3]), 32'sd147456);
        check("t4_00", 32'(dout[0][0]), 32'sd16384);

        for (int t = 5; t < 9; t++) begin
            randomize_model();
            run_op(t, t[0]);
        end

        // Reset mid-operation: outputs must clear without waiting for a clock edge
        randomize_model();
        drive_inputs();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (19) @(negedge clock);
        #2 nreset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_out_nonzero", count_nonzero(), 0);
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);
        randomize_model();
        run_op(10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
